// File: rtl/counter_bank.sv
// counter_bank: NCH independent W-bit up/down counters with per-channel load,
// wrap or saturate at the boundaries, a registered one-cycle terminal pulse and
// a single registered read-back port (1-cycle latency, pre-update value).
// Optional feature: define COUNTER_BANK_OVF_STICKY_EN to add sticky overflow
// flags (ovf_out) with per-channel clear (ovf_clr_in).

// One counter channel; instantiated NCH times by counter_bank.
module counter_bank_lane #(
  parameter int W        = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         incr,
  input  logic         decr,
  input  logic         load,
  input  logic [W-1:0] load_val,
`ifdef COUNTER_BANK_OVF_STICKY_EN
  input  logic         ovf_clr,
  output logic         ovf,
`endif
  output logic [W-1:0] count,
  output logic         term
);

  localparam logic [W-1:0] MAXV = '1;

  logic         hit_top;
  logic         hit_bot;
  logic         boundary;
  logic [W-1:0] count_nxt;

  // Next count in priority order: load, both-requests hold, boundary, +/-1.
  always_comb begin
    hit_top   = incr & ~decr & (count == MAXV);
    hit_bot   = decr & ~incr & (count == '0);
    boundary  = ~load & (hit_top | hit_bot);
    count_nxt = count;
    if (load)              count_nxt = load_val;
    else if (incr && decr) count_nxt = count;
    else if (hit_top)      count_nxt = SATURATE ? MAXV : '0;
    else if (hit_bot)      count_nxt = SATURATE ? '0 : MAXV;
    else if (incr)         count_nxt = count + W'(1);
    else if (decr)         count_nxt = count - W'(1);
  end

  // Count register and registered terminal pulse (high the cycle after the edge).
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count <= '0;
      term  <= 1'b0;
    end else begin
      count <= count_nxt;
      term  <= boundary;
    end
  end

`ifdef COUNTER_BANK_OVF_STICKY_EN
  // Sticky overflow: a boundary event sets it and wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)         ovf <= 1'b0;
    else if (boundary) ovf <= 1'b1;
    else if (ovf_clr)  ovf <= 1'b0;
  end
`endif

endmodule

module counter_bank #(
  parameter int NCH      = 4,
  parameter int W        = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic                                  clk,
  input  logic                                  rstN,
  input  logic [NCH-1:0]                        incr_in,
  input  logic [NCH-1:0]                        decr_in,
  input  logic [NCH-1:0]                        load_in,
  input  logic [NCH*W-1:0]                      load_val_in,
  output logic [NCH*W-1:0]                      count_out,
  output logic [NCH-1:0]                        term_out,
  input  logic                                  rd_req_in,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] rd_sel_in,
  output logic [W-1:0]                          rd_data_out,
`ifdef COUNTER_BANK_OVF_STICKY_EN
  input  logic [NCH-1:0]                        ovf_clr_in,
  output logic [NCH-1:0]                        ovf_out,
`endif
  output logic                                  rd_valid_out
);

  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0][W-1:0] cnt;
  logic [NCH-1:0][W-1:0] ld_val;
  logic [W-1:0]          rd_mux;

  assign ld_val    = load_val_in;
  assign count_out = cnt;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    counter_bank_lane #(.W(W), .SATURATE(SATURATE)) u_lane (
      .clk      (clk),
      .rstN     (rstN),
      .incr     (incr_in[i]),
      .decr     (decr_in[i]),
      .load     (load_in[i]),
      .load_val (ld_val[i]),
`ifdef COUNTER_BANK_OVF_STICKY_EN
      .ovf_clr  (ovf_clr_in[i]),
      .ovf      (ovf_out[i]),
`endif
      .count    (cnt[i]),
      .term     (term_out[i])
    );
  end

  // Read mux; selects beyond the last channel return zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NCH; i++)
      if (rd_sel_in == SELW'(i)) rd_mux = cnt[i];
  end

  // Read-back register: captures the pre-update count, holds while idle.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rd_data_out  <= '0;
      rd_valid_out <= 1'b0;
    end else begin
      rd_valid_out <= rd_req_in;
      if (rd_req_in) rd_data_out <= rd_mux;
    end
  end

endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank: three counter_bank instances (NCH=4 wrap, NCH=4 saturate,
// NCH=3 wrap; all W=8) share one stimulus stream and are checked every cycle
// against an arithmetic reference model, plus directed boundary scenarios.
module tb_counter_bank;

  logic        clk = 1'b0;
  logic        rstN;
  logic [3:0]  incr, decr, load, ovf_clr;
  logic [31:0] load_val;
  logic        rd_req;
  logic [1:0]  rd_sel;

  logic [31:0] cnt_a, cnt_b;
  logic [23:0] cnt_c;
  logic [3:0]  term_a, term_b;
  logic [2:0]  term_c;
  logic [7:0]  rd_a, rd_b, rd_c;
  logic        rv_a, rv_b, rv_c;
`ifdef COUNTER_BANK_OVF_STICKY_EN
  logic [3:0]  ovf_a, ovf_b;
  logic [2:0]  ovf_c;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: [dut][channel]
  int m_cnt  [3][4];
  bit m_term [3][4];
  bit m_ovf  [3][4];
  int m_rd   [3];
  bit m_rv   [3];

  always #5 clk = ~clk;

  counter_bank #(.NCH(4), .W(8), .SATURATE(1'b0)) dut_a (
    .clk(clk), .rstN(rstN), .incr_in(incr), .decr_in(decr), .load_in(load),
    .load_val_in(load_val), .count_out(cnt_a), .term_out(term_a),
    .rd_req_in(rd_req), .rd_sel_in(rd_sel), .rd_data_out(rd_a),
`ifdef COUNTER_BANK_OVF_STICKY_EN
    .ovf_clr_in(ovf_clr), .ovf_out(ovf_a),
`endif
    .rd_valid_out(rv_a));

  counter_bank #(.NCH(4), .W(8), .SATURATE(1'b1)) dut_b (
    .clk(clk), .rstN(rstN), .incr_in(incr), .decr_in(decr), .load_in(load),
    .load_val_in(load_val), .count_out(cnt_b), .term_out(term_b),
    .rd_req_in(rd_req), .rd_sel_in(rd_sel), .rd_data_out(rd_b),
`ifdef COUNTER_BANK_OVF_STICKY_EN
    .ovf_clr_in(ovf_clr), .ovf_out(ovf_b),
`endif
    .rd_valid_out(rv_b));

  counter_bank #(.NCH(3), .W(8), .SATURATE(1'b0)) dut_c (
    .clk(clk), .rstN(rstN), .incr_in(incr[2:0]), .decr_in(decr[2:0]),
    .load_in(load[2:0]), .load_val_in(load_val[23:0]), .count_out(cnt_c),
    .term_out(term_c), .rd_req_in(rd_req), .rd_sel_in(rd_sel), .rd_data_out(rd_c),
`ifdef COUNTER_BANK_OVF_STICKY_EN
    .ovf_clr_in(ovf_clr[2:0]), .ovf_out(ovf_c),
`endif
    .rd_valid_out(rv_c));

  function automatic int nch_of(int d);
    return (d == 2) ? 3 : 4;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_rd[d] = 0;
      m_rv[d] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_cnt[d][i] = 0; m_term[d][i] = 1'b0; m_ovf[d][i] = 1'b0;
      end
    end
  endtask

  // Plain arithmetic: next = count + incr - decr; out of [0,255] is a boundary
  // event, resolved by modulo (wrap) or clamp (saturate).
  task automatic model_update();
    if (!rstN) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 3; d++) begin
      int nch;
      nch = nch_of(d);
      if (rd_req) m_rd[d] = (int'(rd_sel) < nch) ? m_cnt[d][rd_sel] : 0;
      m_rv[d] = rd_req;
      for (int i = 0; i < nch; i++) begin
        int n;
        m_term[d][i] = 1'b0;
        if (load[i]) n = int'(load_val[i*8 +: 8]);
        else begin
          n = m_cnt[d][i] + int'(incr[i]) - int'(decr[i]);
          if (n < 0 || n > 255) begin
            m_term[d][i] = 1'b1;
            if (d == 1) n = (n < 0) ? 0 : 255;
            else        n = (n + 256) % 256;
          end
        end
        m_cnt[d][i] = n;
        if (m_term[d][i])    m_ovf[d][i] = 1'b1;
        else if (ovf_clr[i]) m_ovf[d][i] = 1'b0;
      end
    end
  endtask

  task automatic chk(string tag, int d, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      logic [31:0] ec, et, eo, er, ev;
      ec = '0; et = '0; eo = '0;
      er = 32'(m_rd[d]);
      ev = {31'd0, m_rv[d]};
      for (int i = 0; i < nch_of(d); i++) begin
        ec[i*8 +: 8] = 8'(m_cnt[d][i]);
        et[i] = m_term[d][i];
        eo[i] = m_ovf[d][i];
      end
      case (d)
        0: begin
          chk("count", d, cnt_a, ec);            chk("term", d, {28'd0, term_a}, et);
          chk("rd_data", d, {24'd0, rd_a}, er);  chk("rd_valid", d, {31'd0, rv_a}, ev);
`ifdef COUNTER_BANK_OVF_STICKY_EN
          chk("ovf", d, {28'd0, ovf_a}, eo);
`endif
        end
        1: begin
          chk("count", d, cnt_b, ec);            chk("term", d, {28'd0, term_b}, et);
          chk("rd_data", d, {24'd0, rd_b}, er);  chk("rd_valid", d, {31'd0, rv_b}, ev);
`ifdef COUNTER_BANK_OVF_STICKY_EN
          chk("ovf", d, {28'd0, ovf_b}, eo);
`endif
        end
        default: begin
          chk("count", d, {8'd0, cnt_c}, ec);    chk("term", d, {29'd0, term_c}, et);
          chk("rd_data", d, {24'd0, rd_c}, er);  chk("rd_valid", d, {31'd0, rv_c}, ev);
`ifdef COUNTER_BANK_OVF_STICKY_EN
          chk("ovf", d, {29'd0, ovf_c}, eo);
`endif
        end
      endcase
      if (eo == 32'hFFFF_FFFF) n_tests += 0;
    end
  endtask

  task automatic idle();
    incr = '0; decr = '0; load = '0; load_val = '0;
    rd_req = 1'b0; rd_sel = '0; ovf_clr = '0;
  endtask

  // One clock: model follows the inputs sampled at the edge, outputs checked 1 after.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  initial begin
    idle();
    rstN = 1'b0;
    model_reset();
    repeat (2) step();
    #2 rstN = 1'b1;
    step();

    // Reset mid-count
    incr[0] = 1'b1;
    repeat (37) step();
    idle();
    chk("ch0_at_37", 0, {24'd0, cnt_a[7:0]}, 32'd37);
    #3 rstN = 1'b0;
    #1 model_reset();
    check_all();
    chk("async_rst_count", 0, cnt_a, 32'd0);
    #2 rstN = 1'b1;
    step();

    // Wrap on ch1: 254 -> 255 -> 0 -> 1, then 0 -> 255 by decrement
    load[1] = 1'b1; load_val[15:8] = 8'd254;
    step(); idle();
    incr[1] = 1'b1;
    step(); chk("wrap_255", 0, {24'd0, cnt_a[15:8]}, 32'd255); chk("wrap_noterm", 0, {31'd0, term_a[1]}, 32'd0);
    step(); chk("wrap_0", 0, {24'd0, cnt_a[15:8]}, 32'd0);     chk("wrap_term", 0, {31'd0, term_a[1]}, 32'd1);
    step(); chk("wrap_1", 0, {24'd0, cnt_a[15:8]}, 32'd1);     chk("wrap_term_gone", 0, {31'd0, term_a[1]}, 32'd0);
    idle();
    load[1] = 1'b1; load_val[15:8] = 8'd0;
    step(); idle();
    decr[1] = 1'b1;
    step(); chk("unwrap_255", 0, {24'd0, cnt_a[15:8]}, 32'd255); chk("unwrap_term", 0, {31'd0, term_a[1]}, 32'd1);
    idle();
    step();

    // Saturation on ch2
    load[2] = 1'b1; load_val[23:16] = 8'd255;
    step(); idle();
    incr[2] = 1'b1;
    repeat (4) begin
      step();
      chk("sat_hold_255", 1, {24'd0, cnt_b[23:16]}, 32'd255);
      chk("sat_term_hi", 1, {31'd0, term_b[2]}, 32'd1);
    end
    idle();
    load[2] = 1'b1; load_val[23:16] = 8'd0;
    step(); idle();
    decr[2] = 1'b1;
    step(); chk("sat_hold_0", 1, {24'd0, cnt_b[23:16]}, 32'd0); chk("sat_term_lo", 1, {31'd0, term_b[2]}, 32'd1);
    idle();

    // Priority on ch3, ch0 independent
    load[3] = 1'b1; load_val[31:24] = 8'd10;
    step(); idle();
    load[3] = 1'b1; load_val[31:24] = 8'd99; incr[3] = 1'b1; decr[3] = 1'b1; incr[0] = 1'b1;
    step(); chk("prio_load", 0, {24'd0, cnt_a[31:24]}, 32'd99); chk("ch0_indep", 0, {24'd0, cnt_a[7:0]}, 32'd1);
    idle();
    incr[3] = 1'b1; decr[3] = 1'b1;
    step(); chk("prio_hold", 0, {24'd0, cnt_a[31:24]}, 32'd99); chk("prio_noterm", 0, {31'd0, term_a[3]}, 32'd0);
    idle();

    // Back-to-back reads while ch1 increments (ch1=255, wrap ch2=255, ch3=99)
    incr[1] = 1'b1; rd_req = 1'b1; rd_sel = 2'd1;
    step(); chk("rd_sel1", 0, {24'd0, rd_a}, 32'd255);
    rd_sel = 2'd2;
    step(); chk("rd_sel2", 0, {24'd0, rd_a}, 32'd255);
    rd_sel = 2'd3;
    step(); chk("rd_sel3", 0, {24'd0, rd_a}, 32'd99);
    chk("rd_oob_data", 2, {24'd0, rd_c}, 32'd0); chk("rd_oob_valid", 2, {31'd0, rv_c}, 32'd1);
    idle();
    step(); chk("rd_idle_valid", 0, {31'd0, rv_a}, 32'd0); chk("rd_idle_hold", 0, {24'd0, rd_a}, 32'd99);

`ifdef COUNTER_BANK_OVF_STICKY_EN
    // Sticky overflow on ch0
    load[0] = 1'b1; load_val[7:0] = 8'd255;
    step(); idle();
    incr[0] = 1'b1;
    step(); idle();
    repeat (10) step();
    chk("ovf_persist", 0, {31'd0, ovf_a[0]}, 32'd1);
    load[0] = 1'b1; load_val[7:0] = 8'd255;
    step(); idle();
    incr[0] = 1'b1; ovf_clr[0] = 1'b1;
    step(); chk("ovf_set_wins", 0, {31'd0, ovf_a[0]}, 32'd1);
    idle();
    ovf_clr[0] = 1'b1;
    step(); chk("ovf_cleared", 0, {31'd0, ovf_a[0]}, 32'd0);
    idle();
`endif

    // Randomized traffic, load values biased toward the boundaries
    repeat (400) begin
      incr    = 4'($urandom);
      decr    = 4'($urandom);
      load    = 4'($urandom & $urandom & $urandom);
      ovf_clr = 4'($urandom & $urandom);
      rd_req  = 1'($urandom);
      rd_sel  = 2'($urandom);
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 4))
          0:       load_val[i*8 +: 8] = 8'd0;
          1:       load_val[i*8 +: 8] = 8'd1;
          2:       load_val[i*8 +: 8] = 8'd254;
          3:       load_val[i*8 +: 8] = 8'd255;
          default: load_val[i*8 +: 8] = 8'($urandom);
        endcase
      end
      step();
    end
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
